// File: rtl/pgd_pkg.sv
// Shared types and constants for the priority grant decoder.
// Holds the default index width, the FSM state type and a one-hot helper.
package pgd_pkg;

    localparam int unsigned PGD_IDX_W   = 3;
    localparam int unsigned PGD_N_LINES = 1 << PGD_IDX_W;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StGap
    } pgd_state_t;

    function automatic logic [PGD_N_LINES-1:0] onehot(input logic [PGD_IDX_W-1:0] idx);
        logic [PGD_N_LINES-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/pending_msb_pick.sv
// Combinational pick of the highest set bit of the pending mask.
// any_o flags a non-empty mask; msb_idx_o is 0 when the mask is empty.
module pending_msb_pick
    import pgd_pkg::*;
#(
    parameter int unsigned IDX_W   = PGD_IDX_W,
    parameter int unsigned N_LINES = 1 << IDX_W
) (
    input  logic [N_LINES-1:0] mask_i,
    output logic               any_o,
    output logic [IDX_W-1:0]   msb_idx_o
);

    always_comb begin
        any_o     = |mask_i;
        msb_idx_o = '0;
        // Ascending scan: the last set bit seen is the highest one.
        for (int i = 0; i < int'(N_LINES); i++) begin
            if (mask_i[i]) begin
                msb_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/priority_grant_decoder.sv
// Decodes encoded request indices into a pending mask and replays them as one-hot grants,
// highest index first, with a fixed idle gap after each grant handshake.
module priority_grant_decoder
    import pgd_pkg::*;
#(
    parameter int unsigned IDX_W      = PGD_IDX_W,
    parameter int unsigned GAP_CYCLES = 2,
    localparam int unsigned N_LINES   = 1 << IDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               idx_valid,
    input  logic [IDX_W-1:0]   idx,
    output logic               idx_ready,
    output logic               dup,
    output logic               grant_valid,
    output logic [N_LINES-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    input  logic               grant_ready,
    output logic [N_LINES-1:0] pending
);

    localparam int unsigned CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    pgd_state_t state_q, state_d;

    logic [N_LINES-1:0] pending_q, pending_d;
    logic [N_LINES-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic               grant_valid_q, grant_valid_d;
    logic               dup_q, dup_d;
    logic               idx_ready_q;
    logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic               accept;
    logic               load;
    logic               handshake;
    logic [N_LINES-1:0] set_mask;
    logic [N_LINES-1:0] clr_mask;

    pending_msb_pick #(
        .IDX_W   (IDX_W),
        .N_LINES (N_LINES)
    ) u_pick (
        .mask_i    (pending_q),
        .any_o     (pick_any),
        .msb_idx_o (pick_idx)
    );

    assign accept    = idx_valid & idx_ready_q;
    assign load      = (state_q == StIdle) & pick_any;
    assign handshake = (state_q == StGrant) & grant_valid_q & grant_ready;

    // Set wins over clear, so a request landing on the bit being loaded stays pending.
    always_comb begin
        set_mask  = accept ? (N_LINES'(1) << idx) : '0;
        clr_mask  = load ? (N_LINES'(1) << pick_idx) : '0;
        pending_d = (pending_q & ~clr_mask) | set_mask;
        dup_d     = accept & pending_q[idx] & ~clr_mask[idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) state_d = StGrant;
            end
            StGrant: begin
                if (handshake) state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
            end
            StGap: begin
                if (gap_cnt_q <= CNT_W'(1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        grant_valid_d = grant_valid_q;
        grant_d       = grant_q;
        grant_idx_d   = grant_idx_q;
        gap_cnt_d     = gap_cnt_q;
        if (load) begin
            grant_valid_d = 1'b1;
            grant_idx_d   = pick_idx;
            grant_d       = N_LINES'(1) << pick_idx;
        end
        if (handshake) begin
            grant_valid_d = 1'b0;
            grant_d       = '0;
            gap_cnt_d     = CNT_W'(GAP_CYCLES);
        end
        if (state_q == StGap) begin
            gap_cnt_d = gap_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q     <= '0;
            grant_q       <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            dup_q         <= 1'b0;
            idx_ready_q   <= 1'b0;
            gap_cnt_q     <= '0;
        end else begin
            pending_q     <= pending_d;
            grant_q       <= grant_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            dup_q         <= dup_d;
            idx_ready_q   <= 1'b1;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign idx_ready   = idx_ready_q;
    assign dup         = dup_q;
    assign grant_valid = grant_valid_q;
    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_priority_grant_decoder.sv
// Directed self-checking bench for priority_grant_decoder.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_priority_grant_decoder;

    logic       clk;
    logic       rst_n;
    logic       idx_valid;
    logic [2:0] idx;
    logic       idx_ready;
    logic       dup;
    logic       grant_valid;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_ready;
    logic [7:0] pending;

    int n_checks;
    int n_errors;
    int n_want;
    int n_all;
    int n_seen;

    priority_grant_decoder #(
        .IDX_W      (3),
        .GAP_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .idx_valid   (idx_valid),
        .idx         (idx),
        .idx_ready   (idx_ready),
        .dup         (dup),
        .grant_valid (grant_valid),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_ready (grant_ready),
        .pending     (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] v);
        idx_valid = 1'b1;
        idx       = v;
        step();
        idx_valid = 1'b0;
    endtask

    task automatic collect(input int cycles, input logic [2:0] want,
                           output int got_want, output int got_all);
        got_want = 0;
        got_all  = 0;
        for (int i = 0; i < cycles; i++) begin
            if (grant_valid && grant_ready) begin
                got_all++;
                if (grant_idx == want) got_want++;
            end
            step();
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        idx_valid   = 1'b1;
        idx         = 3'd7;
        grant_ready = 1'b0;

        // Reset held with a request on the input.
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst_outs", {idx_ready, dup, grant_valid, grant, grant_idx}, '0);
            check_eq("rst_pend", pending, 8'h00);
        end
        rst_n     = 1'b1;
        idx_valid = 1'b0;
        step();
        check_eq("rdy_after_rst", idx_ready, 1'b1);
        check_eq("no_grant_after_rst", grant_valid, 1'b0);
        check_eq("pend_after_rst", pending, 8'h00);

        // Basic latency and gap.
        grant_ready = 1'b1;
        send(3'd5);
        check_eq("t2_pend", pending, 8'h20);
        check_eq("t2_gv_t1", grant_valid, 1'b0);
        step();
        check_eq("t2_gv", grant_valid, 1'b1);
        check_eq("t2_grant", grant, 8'h20);
        check_eq("t2_gidx", grant_idx, 3'd5);
        step();
        check_eq("t2_gv_drop", grant_valid, 1'b0);
        check_eq("t2_grant_drop", grant, 8'h00);
        check_eq("t2_pend_clr", pending, 8'h00);
        send(3'd2);
        check_eq("t2_gap_a", grant_valid, 1'b0);
        step();
        check_eq("t2_gap_b", grant_valid, 1'b0);
        step();
        check_eq("t2_next_gv", grant_valid, 1'b1);
        check_eq("t2_next_grant", grant, 8'h04);
        for (int i = 0; i < 6; i++) step();

        // Stall then drain in priority order.
        grant_ready = 1'b0;
        send(3'd1);
        send(3'd7);
        send(3'd4);
        check_eq("t3_pend", pending, 8'h90);
        for (int i = 0; i < 9; i++) begin
            check_eq("t3_hold", {grant_valid, grant_idx, grant}, {1'b1, 3'd1, 8'h02});
            step();
        end
        check_eq("t3_hold_last", {grant_valid, grant_idx, grant}, {1'b1, 3'd1, 8'h02});
        grant_ready = 1'b1;
        step();
        check_eq("t3_drop1", grant_valid, 1'b0);
        step();
        step();
        check_eq("t3_gap1", grant_valid, 1'b0);
        step();
        check_eq("t3_g7", {grant_valid, grant_idx, grant}, {1'b1, 3'd7, 8'h80});
        step();
        check_eq("t3_drop2", grant_valid, 1'b0);
        step();
        step();
        check_eq("t3_gap2", grant_valid, 1'b0);
        step();
        check_eq("t3_g4", {grant_valid, grant_idx, grant}, {1'b1, 3'd4, 8'h10});
        step();
        check_eq("t3_empty", {grant_valid, pending}, 9'h000);
        for (int i = 0; i < 6; i++) step();

        // Duplicate coalescing behind an in-flight grant.
        grant_ready = 1'b0;
        send(3'd0);
        send(3'd3);
        check_eq("t4_dup_a", dup, 1'b0);
        step();
        check_eq("t4_dup_b", dup, 1'b0);
        send(3'd3);
        check_eq("t4_dup_pulse", dup, 1'b1);
        step();
        check_eq("t4_dup_end", dup, 1'b0);
        check_eq("t4_pend", pending, 8'h08);
        grant_ready = 1'b1;
        collect(20, 3'd3, n_want, n_all);
        check_eq("t4_n3", n_want, 1);
        check_eq("t4_nall", n_all, 2);

        // Set and clear of the same bit in one cycle.
        send(3'd6);
        send(3'd6);
        check_eq("t5_dup", dup, 1'b0);
        check_eq("t5_pend", pending, 8'h40);
        check_eq("t5_g6", {grant_valid, grant_idx}, {1'b1, 3'd6});
        collect(15, 3'd6, n_want, n_all);
        check_eq("t5_n6", n_want, 2);
        check_eq("t5_nall", n_all, 2);

        // Reset in the middle of a grant.
        grant_ready = 1'b0;
        send(3'd7);
        send(3'd2);
        check_eq("t6_g7", {grant_valid, grant}, {1'b1, 8'h80});
        rst_n = 1'b0;
        step();
        check_eq("t6_rst_outs", {idx_ready, dup, grant_valid, grant, grant_idx}, '0);
        check_eq("t6_rst_pend", pending, 8'h00);
        rst_n       = 1'b1;
        grant_ready = 1'b1;
        n_seen      = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (grant_valid) n_seen++;
        end
        check_eq("t6_no_grant", n_seen, 0);
        check_eq("t6_pend_final", pending, 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
